// File: rtl/shared_clause_importer.sv
`default_nettype none
// =============================================================================
// Module   : shared_clause_importer
// Filters incoming shared-clause packets by LBD and streams their literals.
// Revision : 1.0
// =============================================================================
module shared_clause_importer #(
   parameter int LBD_MAX = 6,
   parameter int MAX_LEN = 64,
   parameter int CNT_W   = 16,
   parameter int PTR_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pkt_valid,
   output logic             pkt_ready,
   input  logic [95:0]      pkt_data,
   input  logic             flush,
   output logic             mem_req_valid,
   input  logic             mem_req_ready,
   output logic [PTR_W-1:0] mem_req_addr,
   input  logic             mem_rsp_valid,
   input  logic [31:0]      mem_rsp_data,
   output logic             lit_valid,
   input  logic             lit_ready,
   output logic [31:0]      lit_data,
   output logic             lit_first,
   output logic             lit_last,
   output logic [7:0]       lit_lbd,
   output logic [15:0]      lit_len,
   output logic             busy,
   output logic [CNT_W-1:0] imported_cnt,
   output logic [CNT_W-1:0] dropped_cnt
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_EMIT_VAL = 3'd1,
      S_REQ      = 3'd2,
      S_WAIT_RSP = 3'd3,
      S_EMIT_REF = 3'd4,
      S_DRAIN    = 3'd5
   } state_t;

   localparam logic [7:0]       C_LBD_MAX = 8'(LBD_MAX);
   localparam logic [15:0]      C_MAX_LEN = 16'(MAX_LEN);
   localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

   state_t             state_q, state_d;
   logic [7:0]         lbd_q, lbd_d;
   logic [15:0]        len_q, len_d;
   logic [15:0]        idx_q, idx_d;
   logic [31:0]        lit1_q, lit1_d;
   logic [31:0]        lit2_q, lit2_d;
   logic [31:0]        rsp_q, rsp_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]   imp_q, drop_q;
   logic               inc_imp, inc_drop;

   logic [7:0]         w_pkt_lbd;
   logic               w_pkt_is_ref;
   logic [15:0]        w_pkt_len;
   logic               w_accept;
   logic               w_bad;
   logic               w_emit;
   logic               w_last;
   logic               w_unused_reserved;

   assign w_pkt_lbd         = pkt_data[95:88];
   assign w_pkt_is_ref      = pkt_data[87];
   assign w_pkt_len         = pkt_data[79:64];
   assign w_unused_reserved = ^pkt_data[86:80];

   assign w_accept = pkt_valid & (state_q == S_IDLE);
   assign w_bad    = (w_pkt_lbd > C_LBD_MAX)
                   | (!w_pkt_is_ref & (w_pkt_len != 16'd1) & (w_pkt_len != 16'd2))
                   | (w_pkt_is_ref & ((w_pkt_len == 16'd0) | (w_pkt_len > C_MAX_LEN)));
   assign w_emit   = (state_q == S_EMIT_VAL) | (state_q == S_EMIT_REF);
   assign w_last   = (idx_q == len_q - 16'd1);

   assign pkt_ready     = (state_q == S_IDLE);
   assign busy          = (state_q != S_IDLE);
   assign mem_req_valid = (state_q == S_REQ);
   assign mem_req_addr  = ptr_q + PTR_W'(idx_q);
   assign lit_valid     = w_emit;
   assign lit_first     = w_emit & (idx_q == 16'd0);
   assign lit_last      = w_emit & w_last;
   assign lit_lbd       = lbd_q;
   assign lit_len       = len_q;
   assign imported_cnt  = imp_q;
   assign dropped_cnt   = drop_q;

   always_comb begin
      lit_data = 32'd0;
      if (state_q == S_EMIT_VAL) begin
         lit_data = (idx_q == 16'd0) ? lit1_q : lit2_q;
      end else if (state_q == S_EMIT_REF) begin
         lit_data = rsp_q;
      end
   end

   always_comb begin
      state_d  = state_q;
      lbd_d    = lbd_q;
      len_d    = len_q;
      idx_d    = idx_q;
      lit1_d   = lit1_q;
      lit2_d   = lit2_q;
      rsp_d    = rsp_q;
      ptr_d    = ptr_q;
      inc_imp  = 1'b0;
      inc_drop = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               if (flush | w_bad) begin
                  inc_drop = 1'b1;
               end else begin
                  lbd_d = w_pkt_lbd;
                  len_d = w_pkt_len;
                  idx_d = 16'd0;
                  if (w_pkt_is_ref) begin
                     ptr_d   = pkt_data[PTR_W-1:0];
                     state_d = S_REQ;
                  end else begin
                     lit1_d  = pkt_data[63:32];
                     lit2_d  = pkt_data[31:0];
                     state_d = S_EMIT_VAL;
                  end
               end
            end
         end
         S_EMIT_VAL: begin
            if (flush) begin
               inc_drop = 1'b1;
               state_d  = S_IDLE;
            end else if (lit_ready) begin
               if (w_last) begin
                  inc_imp = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  idx_d = idx_q + 16'd1;
               end
            end
         end
         S_REQ: begin
            // A request accepted in the flush cycle still owes us a response.
            if (flush) begin
               inc_drop = 1'b1;
               state_d  = mem_req_ready ? S_DRAIN : S_IDLE;
            end else if (mem_req_ready) begin
               state_d = S_WAIT_RSP;
            end
         end
         S_WAIT_RSP: begin
            // If the response lands in the flush cycle there is nothing left to drain.
            if (flush) begin
               inc_drop = 1'b1;
               state_d  = mem_rsp_valid ? S_IDLE : S_DRAIN;
            end else if (mem_rsp_valid) begin
               rsp_d   = mem_rsp_data;
               state_d = S_EMIT_REF;
            end
         end
         S_EMIT_REF: begin
            if (flush) begin
               inc_drop = 1'b1;
               state_d  = S_IDLE;
            end else if (lit_ready) begin
               if (w_last) begin
                  inc_imp = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  idx_d   = idx_q + 16'd1;
                  state_d = S_REQ;
               end
            end
         end
         S_DRAIN: begin
            if (flush) begin
               inc_drop = 1'b1;
               state_d  = S_IDLE;
            end else if (mem_rsp_valid) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         lbd_q   <= 8'd0;
         len_q   <= 16'd0;
         idx_q   <= 16'd0;
         lit1_q  <= 32'd0;
         lit2_q  <= 32'd0;
         rsp_q   <= 32'd0;
         ptr_q   <= '0;
         imp_q   <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         lbd_q   <= lbd_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         lit1_q  <= lit1_d;
         lit2_q  <= lit2_d;
         rsp_q   <= rsp_d;
         ptr_q   <= ptr_d;
         if (inc_imp && (imp_q != C_CNT_MAX)) begin
            imp_q <= imp_q + 1'b1;
         end
         if (inc_drop && (drop_q != C_CNT_MAX)) begin
            drop_q <= drop_q + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_shared_clause_importer.sv
`default_nettype none
// Testbench for shared_clause_importer: directed table, hand-written corner
// sequences, and a randomized run against a packet-level reference model.
module tb_shared_clause_importer;

   logic        clk = 1'b0;
   logic        rst;
   logic        pkt_valid;
   logic        pkt_ready;
   logic [95:0] pkt_data;
   logic        flush;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        lit_valid;
   logic        lit_ready;
   logic [31:0] lit_data;
   logic        lit_first;
   logic        lit_last;
   logic [7:0]  lit_lbd;
   logic [15:0] lit_len;
   logic        busy;
   logic [15:0] imported_cnt;
   logic [15:0] dropped_cnt;

   always #5 clk = ~clk;

   shared_clause_importer dut (
      .clk           (clk),
      .rst           (rst),
      .pkt_valid     (pkt_valid),
      .pkt_ready     (pkt_ready),
      .pkt_data      (pkt_data),
      .flush         (flush),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_addr  (mem_req_addr),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data),
      .lit_valid     (lit_valid),
      .lit_ready     (lit_ready),
      .lit_data      (lit_data),
      .lit_first     (lit_first),
      .lit_last      (lit_last),
      .lit_lbd       (lit_lbd),
      .lit_len       (lit_len),
      .busy          (busy),
      .imported_cnt  (imported_cnt),
      .dropped_cnt   (dropped_cnt)
   );

   typedef struct {
      logic [31:0] d;
      logic        f;
      logic        l;
      logic [7:0]  lbd;
      logic [15:0] len;
   } lit_t;

   typedef struct {
      logic [7:0]  lbd;
      logic        is_ref;
      logic [15:0] len;
      logic [63:0] pl;
      logic        exp_drop;
      int          exp_n;
      logic [31:0] exp0;
      logic [31:0] exp1;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   logic        nx_rst = 1'b1, nx_pv = 1'b0, nx_flush = 1'b0, nx_lr = 1'b1, nx_mrr = 1'b1;
   logic [95:0] nx_pd = '0;
   bit          rand_rdy = 1'b0;
   int          lat_min = 2, lat_max = 2;
   bit          pend_act = 1'b0;
   int          pend_cnt = 0;
   logic [31:0] pend_addr = '0;

   lit_t        got_q[$];
   logic [31:0] got_addr[$];
   lit_t        exp_lits[$];
   logic [31:0] exp_addrs[$];
   int          lv_seen, mrv_seen, first_lv_cyc, acc_cyc, last_hs_cyc;
   bit          accepted;
   bit          hold_pend = 1'b0;
   lit_t        hold_lit;
   int          stall_idx = -1, stall_left = 0;
   int          exp_imp = 0, exp_drop = 0;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      case (a)
         32'h100: return 32'd4;
         32'h101: return 32'hFFFF_FFF7;
         32'h102: return 32'd12;
         default: return {a[15:0] ^ 16'h5A3C, a[31:16] + 16'h0101};
      endcase
   endfunction

   function automatic logic [63:0] pk(input lit_t x);
      return {6'd0, x.d, x.f, x.l, x.lbd, x.len};
   endfunction

   function automatic lit_t mk(input logic [31:0] d, input logic f, input logic l,
                               input logic [7:0] lbd, input logic [15:0] len);
      lit_t x;
      x.d = d; x.f = f; x.l = l; x.lbd = lbd; x.len = len;
      return x;
   endfunction

   function automatic lit_t got_at(input int i);
      lit_t z;
      z = mk(32'd0, 1'b0, 1'b0, 8'd0, 16'd0);
      if (i < got_q.size()) z = got_q[i];
      return z;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Drive at the falling edge, observe 1 time unit later; DUT outputs are
   // register-based, so what is observed is what the next rising edge sees.
   task automatic cycle();
      lit_t cur;
      @(negedge clk);
      cyc++;
      rst       = nx_rst;
      pkt_valid = nx_pv;
      pkt_data  = nx_pd;
      flush     = nx_flush;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      if (pend_act) begin
         pend_cnt--;
         if (pend_cnt <= 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_fn(pend_addr);
            pend_act      = 1'b0;
         end
      end
      if (rand_rdy) begin
         lit_ready     = ($urandom_range(0, 3) != 0);
         mem_req_ready = 1'($urandom_range(0, 1));
      end else begin
         lit_ready     = nx_lr;
         mem_req_ready = nx_mrr;
      end
      if (stall_left > 0 && lit_valid && got_q.size() == stall_idx) begin
         lit_ready = 1'b0;
         stall_left--;
      end
      #1;
      cur = mk(lit_data, lit_first, lit_last, lit_lbd, lit_len);
      if (hold_pend) begin
         chk("hold_valid", 64'(lit_valid), 64'd1);
         chk("hold_fields", pk(cur), pk(hold_lit));
         hold_pend = 1'b0;
      end
      if (lit_valid) begin
         lv_seen++;
         if (first_lv_cyc < 0) first_lv_cyc = cyc;
         if (lit_ready) begin
            got_q.push_back(cur);
            last_hs_cyc = cyc;
         end else if (!flush && !rst) begin
            hold_pend = 1'b1;
            hold_lit  = cur;
         end
      end
      if (mem_req_valid) begin
         mrv_seen++;
         if (mem_req_ready && !rst) begin
            chk("one_outstanding", 64'(pend_act), 64'd0);
            got_addr.push_back(mem_req_addr);
            pend_act  = 1'b1;
            pend_cnt  = $urandom_range(lat_min, lat_max);
            pend_addr = mem_req_addr;
         end
      end
      if (pkt_valid && pkt_ready && !rst) begin
         accepted = 1'b1;
         acc_cyc  = cyc;
      end
      if (rst) pend_act = 1'b0;
   endtask

   task automatic clear_obs();
      got_q.delete();
      got_addr.delete();
      lv_seen = 0; mrv_seen = 0; first_lv_cyc = -1; accepted = 1'b0;
      acc_cyc = -100; last_hs_cyc = -100; hold_pend = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 3000) begin
         cycle();
         n++;
      end
      chk("idle_reached", 64'(busy), 64'd0);
   endtask

   task automatic run_pkt(input logic [7:0] lbd, input logic is_ref,
                          input logic [15:0] len, input logic [63:0] pl);
      int n;
      clear_obs();
      nx_pd = {lbd, is_ref, 7'($urandom), len, pl};
      nx_pv = 1'b1;
      n = 0;
      while (!accepted && n < 50) begin
         cycle();
         n++;
      end
      chk("pkt_accepted", 64'(accepted), 64'd1);
      nx_pv = 1'b0;
      cycle();
      wait_idle();
   endtask

   // Packet-level model: what a clause should turn into, from the filter rules.
   task automatic model(input logic [7:0] lbd, input logic is_ref, input logic [15:0] len,
                        input logic [63:0] pl, output bit drop);
      exp_lits.delete();
      exp_addrs.delete();
      drop = (lbd > 8'd6) || (!is_ref && !(len == 16'd1 || len == 16'd2))
          || (is_ref && (len == 16'd0 || len > 16'd64));
      if (!drop) begin
         for (int i = 0; i < int'(len); i++) begin
            logic [31:0] a, v;
            if (is_ref) begin
               a = pl[31:0] + 32'(i);
               exp_addrs.push_back(a);
               v = mem_fn(a);
            end else begin
               v = (i == 0) ? pl[63:32] : pl[31:0];
            end
            exp_lits.push_back(mk(v, i == 0, i == int'(len) - 1, lbd, len));
         end
      end
   endtask

   task automatic check_vs_model(input bit drop);
      chk("n_lits", 64'(got_q.size()), 64'(exp_lits.size()));
      for (int i = 0; i < exp_lits.size(); i++) chk("lit", pk(got_at(i)), pk(exp_lits[i]));
      chk("n_addr", 64'(got_addr.size()), 64'(exp_addrs.size()));
      for (int i = 0; i < exp_addrs.size() && i < got_addr.size(); i++)
         chk("addr", 64'(got_addr[i]), 64'(exp_addrs[i]));
      if (drop) exp_drop++;
      else      exp_imp++;
      chk("imported_cnt", 64'(imported_cnt), 64'(exp_imp));
      chk("dropped_cnt", 64'(dropped_cnt), 64'(exp_drop));
   endtask

   vec_t tbl[8];

   initial begin
      bit drop;
      int n;
      rst = 1'b1; pkt_valid = 1'b0; pkt_data = '0; flush = 1'b0;
      mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0; lit_ready = 1'b1;

      tbl[0] = '{8'd3, 1'b0, 16'd2,  {32'h5, 32'hFFFF_FFF9}, 1'b0, 2, 32'h5, 32'hFFFF_FFF9};
      tbl[1] = '{8'd3, 1'b0, 16'd1,  {32'hA, 32'hB},         1'b0, 1, 32'hA, 32'h0};
      tbl[2] = '{8'd7, 1'b0, 16'd1,  {32'h1, 32'h2},         1'b1, 0, 32'h0, 32'h0};
      tbl[3] = '{8'd2, 1'b1, 16'd0,  {32'h0, 32'h100},       1'b1, 0, 32'h0, 32'h0};
      tbl[4] = '{8'd2, 1'b0, 16'd3,  {32'h1, 32'h2},         1'b1, 0, 32'h0, 32'h0};
      tbl[5] = '{8'd2, 1'b1, 16'd65, {32'h0, 32'h100},       1'b1, 0, 32'h0, 32'h0};
      tbl[6] = '{8'd6, 1'b0, 16'd1,  {32'h1234, 32'h9},      1'b0, 1, 32'h1234, 32'h0};
      tbl[7] = '{8'd0, 1'b0, 16'd0,  {32'h1, 32'h2},         1'b1, 0, 32'h0, 32'h0};

      repeat (3) cycle();
      chk("rst_pkt_ready", 64'(pkt_ready), 64'd1);
      chk("rst_ctrl", 64'({lit_valid, mem_req_valid, busy, lit_first, lit_last}), 64'd0);
      chk("rst_data", {lit_data, lit_lbd, lit_len, 8'd0}, 64'd0);
      chk("rst_addr", 64'(mem_req_addr), 64'd0);
      chk("rst_cnts", 64'({imported_cnt, dropped_cnt}), 64'd0);
      nx_rst = 1'b0;
      cycle();

      // Table-driven value / drop vectors.
      for (int i = 0; i < 8; i++) begin
         run_pkt(tbl[i].lbd, tbl[i].is_ref, tbl[i].len, tbl[i].pl);
         chk("tbl_n_lits", 64'(got_q.size()), 64'(tbl[i].exp_n));
         if (tbl[i].exp_n >= 1)
            chk("tbl_lit0", pk(got_at(0)), pk(mk(tbl[i].exp0, 1'b1, tbl[i].exp_n == 1, tbl[i].lbd, tbl[i].len)));
         if (tbl[i].exp_n == 2)
            chk("tbl_lit1", pk(got_at(1)), pk(mk(tbl[i].exp1, 1'b0, 1'b1, tbl[i].lbd, tbl[i].len)));
         if (tbl[i].exp_drop) begin
            chk("tbl_drop_quiet", 64'({lv_seen[15:0], mrv_seen[15:0]}), 64'd0);
            exp_drop++;
         end else begin
            chk("tbl_latency", 64'(first_lv_cyc - acc_cyc), 64'd1);
            exp_imp++;
         end
         chk("tbl_imported", 64'(imported_cnt), 64'(exp_imp));
         chk("tbl_dropped", 64'(dropped_cnt), 64'(exp_drop));
      end

      // Reference packet, 2-cycle memory, consumer stalls 3 cycles on the 2nd literal.
      lat_min = 2; lat_max = 2;
      stall_idx = 1; stall_left = 3;
      run_pkt(8'd4, 1'b1, 16'd3, 64'h100);
      chk("stall_applied", 64'(stall_left), 64'd0);
      chk("ref_n_addr", 64'(got_addr.size()), 64'd3);
      for (int i = 0; i < 3 && i < got_addr.size(); i++) chk("ref_addr", 64'(got_addr[i]), 64'h100 + 64'(i));
      chk("ref_lit0", pk(got_at(0)), pk(mk(32'd4, 1'b1, 1'b0, 8'd4, 16'd3)));
      chk("ref_lit1", pk(got_at(1)), pk(mk(32'hFFFF_FFF7, 1'b0, 1'b0, 8'd4, 16'd3)));
      chk("ref_lit2", pk(got_at(2)), pk(mk(32'd12, 1'b0, 1'b1, 8'd4, 16'd3)));
      exp_imp++;
      chk("ref_imported", 64'(imported_cnt), 64'(exp_imp));

      // Pointer wrap.
      run_pkt(8'd1, 1'b1, 16'd2, 64'hFFFF_FFFF);
      chk("wrap_addr0", 64'(got_addr.size() > 0 ? got_addr[0] : 32'h0BAD), 64'hFFFF_FFFF);
      chk("wrap_addr1", 64'(got_addr.size() > 1 ? got_addr[1] : 32'h0BAD), 64'h0);
      model(8'd1, 1'b1, 16'd2, 64'hFFFF_FFFF, drop);
      check_vs_model(drop);

      // Flush while waiting for the response: drain it, emit nothing.
      lat_min = 3; lat_max = 3;
      clear_obs();
      nx_pd = {8'd2, 1'b1, 7'd0, 16'd2, 64'h200};
      nx_pv = 1'b1;
      n = 0;
      while (got_addr.size() == 0 && n < 30) begin
         cycle();
         if (accepted) nx_pv = 1'b0;
         n++;
      end
      nx_pv = 1'b0;
      chk("flush_req_seen", 64'(got_addr.size()), 64'd1);
      nx_flush = 1'b1;
      cycle();
      nx_flush = 1'b0;
      cycle();
      chk("flush_drain_busy", 64'(busy), 64'd1);
      wait_idle();
      chk("flush_rsp_delivered", 64'(pend_act), 64'd0);
      chk("flush_no_lits", 64'(lv_seen), 64'd0);
      chk("flush_one_req", 64'(got_addr.size()), 64'd1);
      exp_drop++;
      chk("flush_dropped", 64'(dropped_cnt), 64'(exp_drop));
      run_pkt(8'd2, 1'b0, 16'd2, {32'd7, 32'd8});
      model(8'd2, 1'b0, 16'd2, {32'd7, 32'd8}, drop);
      check_vs_model(drop);

      // Packet waiting while the previous clause's last literal is taken.
      lat_min = 2; lat_max = 2;
      clear_obs();
      nx_pd = {8'd1, 1'b0, 7'd0, 16'd2, 32'd1, 32'd2};
      nx_pv = 1'b1;
      n = 0;
      while (!accepted && n < 20) begin cycle(); n++; end
      accepted = 1'b0;
      nx_pd = {8'd1, 1'b0, 7'd0, 16'd1, 32'd3, 32'd4};
      n = 0;
      while (!accepted && n < 20) begin cycle(); n++; end
      nx_pv = 1'b0;
      chk("b2b_accept_cycle", 64'(acc_cyc), 64'(last_hs_cyc + 1));
      cycle();
      wait_idle();
      chk("b2b_n_lits", 64'(got_q.size()), 64'd3);
      chk("b2b_lit0", pk(got_at(0)), pk(mk(32'd1, 1'b1, 1'b0, 8'd1, 16'd2)));
      chk("b2b_lit1", pk(got_at(1)), pk(mk(32'd2, 1'b0, 1'b1, 8'd1, 16'd2)));
      chk("b2b_lit2", pk(got_at(2)), pk(mk(32'd3, 1'b1, 1'b1, 8'd1, 16'd1)));
      exp_imp += 2;
      chk("b2b_imported", 64'(imported_cnt), 64'(exp_imp));

      // Randomized packets, backpressure and memory latency.
      rand_rdy = 1'b1;
      lat_min = 1; lat_max = 3;
      for (int k = 0; k < 150; k++) begin
         logic [7:0]  lbd;
         logic        is_ref;
         logic [15:0] len;
         logic [63:0] pl;
         lbd    = 8'($urandom_range(0, 8));
         is_ref = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 7))
            0: len = 16'd0;
            1: len = 16'd1;
            2: len = 16'd2;
            3: len = 16'd3;
            4: len = 16'd64;
            5: len = 16'd65;
            default: len = 16'($urandom_range(1, 4));
         endcase
         pl = {$urandom, $urandom};
         if (is_ref && $urandom_range(0, 3) == 0) pl[31:0] = 32'hFFFF_FFFF - $urandom_range(0, 2);
         model(lbd, is_ref, len, pl, drop);
         run_pkt(lbd, is_ref, len, pl);
         check_vs_model(drop);
      end
      rand_rdy = 1'b0;
      repeat (5) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/shared_clause_importer.md
Name: shared_clause_importer

Overview:
- Receive-side counterpart of the shared-clause exporter. Consumes `shared_packet_t` words arriving from the swarm and filters them by LBD.
- Value packets are unpacked in place. Reference packets are resolved by reading clause literals from global memory, one word per literal.
- Clauses leave as a literal stream with first/last framing, feeding the local clause-insertion logic of a core.

Parameters:
- LBD_MAX, 6, packets with lbd > LBD_MAX are dropped.
- MAX_LEN, 64, reference packets with length > MAX_LEN are dropped.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pkt_valid  in  1  incoming packet valid
- pkt_ready  out  1  importer can accept a packet
- pkt_data  in  96  shared_packet_t {lbd[95:88], is_ref[87], reserved[86:80], length[79:64], payload[63:0]}
- flush  in  1  abort current clause, return to idle
- mem_req_valid  out  1  literal read request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  PTR_W  word address of literal
- mem_rsp_valid  in  1  read data valid (no backpressure)
- mem_rsp_data  in  32  signed literal
- lit_valid  out  1  output literal valid
- lit_ready  in  1  consumer accepts literal
- lit_data  out  32  signed literal
- lit_first  out  1  first literal of clause
- lit_last  out  1  last literal of clause
- lit_lbd  out  8  LBD of current clause
- lit_len  out  16  length of current clause
- busy  out  1  state != IDLE
- imported_cnt  out  CNT_W  clauses fully emitted, saturating
- dropped_cnt  out  CNT_W  packets dropped (LBD, malformed, or flushed), saturating

Behaviour:
- Reset values: every output is 0, except pkt_ready = 1. State is IDLE; counters, index and pointer registers are 0.
- States are IDLE, EMIT_VAL, REQ, WAIT_RSP, EMIT_REF, DRAIN.
- pkt_ready = 1 only in IDLE. A packet is accepted when pkt_valid & pkt_ready.
- Accepted packets are classified in the same cycle, in this priority order:
  - lbd > LBD_MAX: drop.
  - Value packet (is_ref = 0) with length not 1 or 2: drop.
  - Reference packet (is_ref = 1) with length 0 or length > MAX_LEN: drop.
  - Drop means dropped_cnt += 1 and the state stays IDLE.
- The reserved field is ignored.
- Valid value packet: latch lbd, len, lit1 = payload[63:32], lit2 = payload[31:0]. Go to EMIT_VAL.
  - lit_valid is asserted the next cycle (latency 1).
  - Emits lit1, then lit2 if len = 2.
  - lit_first is set on lit1. lit_last is set on the final literal.
  - Advance only on lit_valid & lit_ready.
- Valid reference packet: latch ptr = payload[PTR_W-1:0], len, lbd, and set idx = 0. Go to REQ.
- REQ:
  - mem_req_valid = 1, mem_req_addr = ptr + idx, computed mod 2^PTR_W so the address wraps.
  - On mem_req_ready, go to WAIT_RSP.
  - At most one request is outstanding.
- WAIT_RSP: on mem_rsp_valid, capture mem_rsp_data into a register and go to EMIT_REF. lit_valid rises the following cycle.
- EMIT_REF:
  - lit_first = (idx == 0), lit_last = (idx == len-1).
  - On handshake: if last, go to IDLE; otherwise idx += 1 and go to REQ.
- lit_data, lit_first, lit_last, lit_lbd and lit_len are held stable while lit_valid & !lit_ready (AXI-style hold).
- imported_cnt += 1 on the handshake of the lit_last literal.
- Both counters saturate at 2^CNT_W - 1.
- flush, applied in any non-IDLE state (flush has priority over all other transitions in that cycle):
  - Output is aborted, lit_valid deasserts next cycle, and dropped_cnt += 1.
  - In WAIT_RSP, go to DRAIN. Otherwise go to IDLE.
  - Flush in REQ with mem_req_ready high in the same cycle counts as issued, so go to DRAIN.
- flush in IDLE: no effect, and the packet accepted that cycle is dropped (dropped_cnt += 1).
- DRAIN: wait for mem_rsp_valid, discard the data, go to IDLE.
- mem_rsp_valid in any state other than WAIT_RSP or DRAIN is ignored.
- Reset mid-operation returns to IDLE immediately. Any in-flight response that arrives afterwards is ignored; the memory side must tolerate this.
- Simultaneous lit handshake of the last literal and pkt_valid: the new packet is not accepted until the next cycle (IDLE).

Test Plan:
- Value packet lbd=3, len=2, payload {0x00000005, 0xFFFFFFF9}:
  - Stream is 5 (first), then -7 (last), starting 1 cycle after accept.
  - imported_cnt = 1.
- Value packet len=1, payload {0x0000000A, 0x0000000B}:
  - Single literal 10 with first = last = 1. 0xB is never emitted.
- Reference packet ptr=0x100, len=3, memory returns 4, -9, 12 with 2-cycle latency:
  - Requests go to 0x100, 0x101, 0x102 serially.
  - Output is 4 (first), -9, 12 (last).
  - lit_ready held low for 3 cycles mid-stream: data holds stable.
- Drop cases, one packet each:
  - lbd=7 value packet.
  - Reference packet with len=0.
  - Value packet with len=3.
  - Reference packet with len=65.
  - Required result: dropped_cnt = 4, no lit_valid, no mem_req_valid.
- Reference packet ptr=0xFFFFFFFF, len=2: addresses are 0xFFFFFFFF, then 0x00000000.
- Flush while in WAIT_RSP:
  - State goes to DRAIN, and the late response is discarded without lit_valid.
  - Next value packet is emitted normally.
  - dropped_cnt increments by 1.
